// File: rtl/sprite_readback_if.sv
// Bus bundle for sprite_readback: command inputs, frame-buffer read port,
// packed byte stream and status. The slave modport is the readback engine.
interface sprite_readback_if #(
    parameter int ADDRESS_WIDTH = 18
);
    logic                     start_in;
    logic [9:0]               x_position_in;
    logic [9:0]               y_position_in;
    logic [9:0]               width_in;
    logic [9:0]               height_in;
    logic [4:0]               total_colors_in;
    logic [3:0]               color_palette_offset_in;

    logic                     pixel_read_enable_out;
    logic [ADDRESS_WIDTH-1:0] pixel_read_address_out;
    logic [3:0]               pixel_read_data_in;

    logic                     data_valid_out;
    logic [7:0]               data_out;
    logic                     data_ready_in;

    logic                     busy_out;
    logic                     done_out;

    modport slave (
        input  start_in, x_position_in, y_position_in, width_in, height_in,
               total_colors_in, color_palette_offset_in,
               pixel_read_data_in, data_ready_in,
        output pixel_read_enable_out, pixel_read_address_out,
               data_valid_out, data_out, busy_out, done_out
    );

    modport master (
        output start_in, x_position_in, y_position_in, width_in, height_in,
               total_colors_in, color_palette_offset_in,
               pixel_read_data_in, data_ready_in,
        input  pixel_read_enable_out, pixel_read_address_out,
               data_valid_out, data_out, busy_out, done_out
    );
endinterface

// File: rtl/sprite_readback.sv
// Reads a rectangle of the 4bpp frame buffer in raster order and streams it
// out as bytes in the sprite draw path's packed 2/4/16-colour format.
module sprite_readback #(
    parameter int FRAME_WIDTH   = 640,
    parameter int ADDRESS_WIDTH = 18
) (
    input  logic              clock_in,
    input  logic              reset_n_in,
    sprite_readback_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, OUTPUT, DONE} state_t;

    state_t     state;
    logic [9:0] x_first;
    logic [10:0] x_last;
    logic [10:0] y_last;
    logic [9:0] pen_x;
    logic [9:0] pen_y;
    logic [2:0] bits_per_pixel;
    logic [3:0] palette_offset;
    logic [7:0] pack;
    logic [2:0] pixel_count;
    logic       last_byte;

    logic [2:0] start_bits;
    logic [3:0] field;
    logic [3:0] bits_used;
    logic [2:0] field_shift;
    logic [7:0] pack_next;
    logic       byte_full;
    logic       at_row_end;
    logic       last_pixel;
    logic [9:0] next_x;
    logic [9:0] next_y;

    // 0 marks an illegal colour mode
    function automatic logic [2:0] colors_to_bits(input logic [4:0] colors);
        case (colors)
            5'd2:    return 3'd1;
            5'd4:    return 3'd2;
            5'd16:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Transparent pixel 0 always maps to field 0; others lose the offset.
    function automatic logic [3:0] pixel_to_field(input logic [3:0] pixel,
                                                  input logic [3:0] offset,
                                                  input logic [2:0] bits);
        logic [3:0] mask;
        mask = (bits == 3'd1) ? 4'h1 : (bits == 3'd2) ? 4'h3 : 4'hF;
        return (pixel == 4'd0) ? 4'd0 : ((pixel - offset) & mask);
    endfunction

    function automatic logic [ADDRESS_WIDTH-1:0] pixel_address(input logic [9:0] px,
                                                               input logic [9:0] py);
        return ADDRESS_WIDTH'(32'(px) + 32'(py) * 32'(FRAME_WIDTH));
    endfunction

    always_comb begin
        start_bits  = colors_to_bits(bus.total_colors_in);
        field       = pixel_to_field(bus.pixel_read_data_in, palette_offset, bits_per_pixel);
        bits_used   = 4'(bits_per_pixel) * (4'(pixel_count) + 4'd1);
        field_shift = 3'(4'd8 - bits_used);
        pack_next   = pack | (8'(field) << field_shift);
        byte_full   = (bits_used == 4'd8);
        at_row_end  = ({1'b0, pen_x} >= x_last);
        last_pixel  = at_row_end && ({1'b0, pen_y} >= y_last);
        next_x      = at_row_end ? x_first : pen_x + 10'd1;
        next_y      = at_row_end ? pen_y + 10'd1 : pen_y;
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            state                      <= IDLE;
            x_first                    <= '0;
            x_last                     <= '0;
            y_last                     <= '0;
            pen_x                      <= '0;
            pen_y                      <= '0;
            bits_per_pixel             <= '0;
            palette_offset             <= '0;
            pack                       <= '0;
            pixel_count                <= '0;
            last_byte                  <= 1'b0;
            bus.pixel_read_enable_out  <= 1'b0;
            bus.pixel_read_address_out <= '0;
            bus.data_valid_out         <= 1'b0;
            bus.data_out               <= '0;
            bus.busy_out               <= 1'b0;
            bus.done_out               <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done_out <= 1'b0;
                    if (bus.start_in && start_bits != 3'd0) begin
                        x_first        <= bus.x_position_in;
                        x_last         <= {1'b0, bus.x_position_in} + {1'b0, bus.width_in} - 11'd1;
                        y_last         <= {1'b0, bus.y_position_in} + {1'b0, bus.height_in} - 11'd1;
                        bits_per_pixel <= start_bits;
                        palette_offset <= bus.color_palette_offset_in;
                        pen_x          <= bus.x_position_in;
                        pen_y          <= bus.y_position_in;
                        pack           <= '0;
                        pixel_count    <= '0;
                        if (bus.width_in == 10'd0 || bus.height_in == 10'd0) begin
                            bus.done_out <= 1'b1;
                            state        <= DONE;
                        end else begin
                            bus.pixel_read_address_out <= pixel_address(bus.x_position_in,
                                                                        bus.y_position_in);
                            bus.pixel_read_enable_out  <= 1'b1;
                            bus.busy_out               <= 1'b1;
                            state                      <= READ;
                        end
                    end
                end

                READ: begin
                    bus.pixel_read_enable_out <= 1'b0;
                    state                     <= CAPTURE;
                end

                // Read data is valid here, one cycle after the strobe
                CAPTURE: begin
                    pen_x                      <= next_x;
                    pen_y                      <= next_y;
                    bus.pixel_read_address_out <= pixel_address(next_x, next_y);
                    if (byte_full || last_pixel) begin
                        bus.data_out       <= pack_next;
                        bus.data_valid_out <= 1'b1;
                        pack               <= '0;
                        pixel_count        <= '0;
                        last_byte          <= last_pixel;
                        state              <= OUTPUT;
                    end else begin
                        pack                      <= pack_next;
                        pixel_count               <= pixel_count + 3'd1;
                        bus.pixel_read_enable_out <= 1'b1;
                        state                     <= READ;
                    end
                end

                OUTPUT: begin
                    if (bus.data_ready_in) begin
                        bus.data_valid_out <= 1'b0;
                        if (last_byte) begin
                            bus.busy_out <= 1'b0;
                            bus.done_out <= 1'b1;
                            state        <= DONE;
                        end else begin
                            bus.pixel_read_enable_out <= 1'b1;
                            state                     <= READ;
                        end
                    end
                end

                DONE: begin
                    bus.done_out <= 1'b0;
                    state        <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_readback.sv
// Directed scoreboard bench for sprite_readback: expected read addresses and
// bytes are queued by the stimulus and popped by independent monitors.
module tb_sprite_readback;
    localparam int AW = 18;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sprite_readback_if #(.ADDRESS_WIDTH(AW)) bus();

    sprite_readback #(.FRAME_WIDTH(640), .ADDRESS_WIDTH(AW)) dut (
        .clock_in   (clk),
        .reset_n_in (reset_n),
        .bus        (bus)
    );

    logic [3:0] fb [int];
    int         exp_addr_q[$];
    logic [7:0] exp_byte_q[$];
    int checks = 0;
    int errors = 0;
    int read_count = 0;
    int xfer_count = 0;
    int done_count = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] actual);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h, expected nothing", name, actual);
    endtask

    // Frame-buffer model: one-cycle read latency
    always @(posedge clk) begin
        if (bus.pixel_read_enable_out)
            bus.pixel_read_data_in <= fb.exists(int'(bus.pixel_read_address_out)) ?
                                      fb[int'(bus.pixel_read_address_out)] : 4'd0;
    end

    always @(negedge clk) begin
        if (bus.pixel_read_enable_out) begin
            read_count++;
            if (exp_addr_q.size() == 0) flag("read_addr_extra", 32'(bus.pixel_read_address_out));
            else check("read_addr", 32'(bus.pixel_read_address_out), exp_addr_q.pop_front());
        end
        if (bus.data_valid_out && bus.data_ready_in) begin
            xfer_count++;
            if (exp_byte_q.size() == 0) flag("byte_extra", 32'(bus.data_out));
            else check("byte", 32'(bus.data_out), 32'(exp_byte_q.pop_front()));
        end
        if (bus.done_out) done_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_region(input int x, input int y, input int w, input int h,
                                input int colors, input int off);
        bus.x_position_in           = 10'(x);
        bus.y_position_in           = 10'(y);
        bus.width_in                = 10'(w);
        bus.height_in               = 10'(h);
        bus.total_colors_in         = 5'(colors);
        bus.color_palette_offset_in = 4'(off);
        bus.start_in                = 1'b1;
        tick();
        bus.start_in                = 1'b0;
    endtask

    task automatic push_addresses(input int x, input int y, input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                exp_addr_q.push_back((x + c) + (y + r) * 640);
    endtask

    task automatic wait_done(input string name, input int base);
        int n;
        n = 0;
        while (done_count == base && n < 3000) begin
            tick();
            n++;
        end
        check({name, "_done"}, 32'(done_count), 32'(base + 1));
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!bus.data_valid_out && n < 100) begin
            tick();
            n++;
        end
        check({name, "_valid"}, 32'(bus.data_valid_out), 32'd1);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_rd_en"}, 32'(bus.pixel_read_enable_out), 32'd0);
        check({name, "_rd_addr"}, 32'(bus.pixel_read_address_out), 32'd0);
        check({name, "_valid"}, 32'(bus.data_valid_out), 32'd0);
        check({name, "_data"}, 32'(bus.data_out), 32'd0);
        check({name, "_busy"}, 32'(bus.busy_out), 32'd0);
        check({name, "_done"}, 32'(bus.done_out), 32'd0);
    endtask

    task automatic run_case(input string name, input int x, input int y, input int w, input int h,
                            input int colors, input int off, input int nbytes);
        int base_done, base_xfer;
        base_done = done_count;
        base_xfer = xfer_count;
        push_addresses(x, y, w, h);
        start_region(x, y, w, h, colors, off);
        check({name, "_busy"}, 32'(bus.busy_out), 32'd1);
        wait_done(name, base_done);
        check({name, "_xfers"}, 32'(xfer_count - base_xfer), 32'(nbytes));
        check({name, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
        check({name, "_bytes_left"}, 32'(exp_byte_q.size()), 32'd0);
        check({name, "_busy_end"}, 32'(bus.busy_out), 32'd0);
    endtask

    initial begin
        int base_done, base_xfer, rc;
        logic [7:0] held;

        bus.start_in = 1'b0;
        bus.x_position_in = '0;
        bus.y_position_in = '0;
        bus.width_in = '0;
        bus.height_in = '0;
        bus.total_colors_in = '0;
        bus.color_palette_offset_in = '0;
        bus.data_ready_in = 1'b1;
        bus.pixel_read_data_in = '0;
        reset_n = 1'b0;

        fb[12810] = 4'd1; fb[12811] = 4'd0; fb[12812] = 4'd1; fb[12813] = 4'd1;
        fb[12814] = 4'd0; fb[12815] = 4'd0; fb[12816] = 4'd0; fb[12817] = 4'd1;
        fb[3300] = 4'd4;  fb[3301] = 4'd0;  fb[3302] = 4'd6;  fb[3303] = 4'd5;
        fb[4680] = 4'hA;  fb[4681] = 4'h5;  fb[4682] = 4'h7;
        fb[0] = 4'd1;    fb[1] = 4'd1;    fb[2] = 4'd0;
        fb[640] = 4'd1;  fb[641] = 4'd0;  fb[642] = 4'd1;
        fb[1280] = 4'd0; fb[1281] = 4'd1; fb[1282] = 4'd1;
        fb[19200] = 4'd1; fb[19201] = 4'd2; fb[19202] = 4'd3; fb[19203] = 4'd4;

        tick(3);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        tick();

        exp_byte_q.push_back(8'hB1);
        run_case("mono8", 10, 20, 8, 1, 2, 0, 1);

        exp_byte_q.push_back(8'h4E);
        run_case("c4_off3", 100, 5, 4, 1, 4, 3, 1);

        exp_byte_q.push_back(8'hA5);
        exp_byte_q.push_back(8'h70);
        run_case("c16_pad", 200, 7, 3, 1, 16, 0, 2);

        exp_byte_q.push_back(8'hD5);
        exp_byte_q.push_back(8'h80);
        run_case("rowwrap", 0, 0, 3, 3, 2, 0, 2);

        // Backpressure: byte held while ready is low, reads stall
        exp_byte_q.push_back(8'h12);
        exp_byte_q.push_back(8'h34);
        push_addresses(0, 30, 4, 1);
        base_done = done_count;
        base_xfer = xfer_count;
        bus.data_ready_in = 1'b0;
        start_region(0, 30, 4, 1, 16, 0);
        wait_valid("bp");
        held = bus.data_out;
        rc = read_count;
        check("bp_first_byte", 32'(held), 32'h12);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_data_stable", 32'(bus.data_out), 32'(held));
        end
        check("bp_no_reads", 32'(read_count), 32'(rc));
        check("bp_no_xfer", 32'(xfer_count), 32'(base_xfer));
        bus.data_ready_in = 1'b1;
        wait_done("bp", base_done);
        check("bp_xfers", 32'(xfer_count - base_xfer), 32'd2);
        check("bp_reads_resumed", 32'(read_count), 32'(rc + 2));
        check("bp_bytes_left", 32'(exp_byte_q.size()), 32'd0);

        // Zero width: immediate done, never busy, no reads
        rc = read_count;
        base_done = done_count;
        start_region(5, 5, 0, 4, 4, 0);
        check("w0_done", 32'(bus.done_out), 32'd1);
        check("w0_busy", 32'(bus.busy_out), 32'd0);
        tick();
        check("w0_done_pulse", 32'(bus.done_out), 32'd0);
        check("w0_reads", 32'(read_count), 32'(rc));

        // Illegal colour mode is ignored
        rc = read_count;
        base_done = done_count;
        start_region(5, 5, 4, 1, 8, 0);
        check("c8_busy", 32'(bus.busy_out), 32'd0);
        tick(6);
        check("c8_no_done", 32'(done_count), 32'(base_done));
        check("c8_reads", 32'(read_count), 32'(rc));

        // Reset while a byte is pending
        push_addresses(10, 20, 8, 1);
        bus.data_ready_in = 1'b0;
        start_region(10, 20, 8, 1, 2, 0);
        wait_valid("rst_mid");
        base_done = done_count;
        reset_n = 1'b0;
        tick();
        check_idle_outputs("rst_mid");
        reset_n = 1'b1;
        bus.data_ready_in = 1'b1;
        tick(5);
        check("rst_mid_no_done", 32'(done_count), 32'(base_done));
        check("rst_mid_addr_left", 32'(exp_addr_q.size()), 32'd0);

        exp_byte_q.push_back(8'hB1);
        run_case("after_rst", 10, 20, 8, 1, 2, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
